// File: rtl/dec38_pkg.sv
// Shared types and constants for the 3-to-8 LED / 7-segment display driver.
// Segment patterns are active-low with bit7=a .. bit1=g and bit0=dp.
package dec38_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLINK = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_DIGIT [0:7] = '{
    8'b00000011,
    8'b10011111,
    8'b00100101,
    8'b00001101,
    8'b10011001,
    8'b01001001,
    8'b01000001,
    8'b00011111
  };

  localparam logic [1:0] PHASE_LAST = 2'd3;

  function automatic logic [7:0] seg_digit(input logic [2:0] code);
    return SEG_DIGIT[code];
  endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder; all outputs low when disabled.
module onehot_dec3to8 (
  input  logic       en_i,
  input  logic [2:0] code_i,
  output logic [7:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o[code_i] = 1'b1;
    end
  end

endmodule

// File: rtl/dec38_led_drv.sv
// Accepts a 3-bit index, shows it one-hot on the LEDs for HOLD_CYCLES, blinks it
// twice at BLINK_DIV cycles per half-period, and shows the digit on a 7-seg display.
module dec38_led_drv
  import dec38_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int BLINK_DIV   = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_i,
  input  logic       code_vld_i,
  output logic       code_rdy_o,
  output logic [7:0] led_o,
  output logic [7:0] seg_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       phase_q, phase_d;
  logic             led_en;

  // Handshake: a transfer happens at a rising edge where code_vld_i && code_rdy_o.
  // Ready is a pure function of state, so the source must hold valid until ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (code_vld_i) begin
          code_d  = code_i;
          cnt_d   = '0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          phase_d = '0;
          state_d = ST_BLINK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLINK: begin
        if (cnt_q == BLINK_LAST) begin
          cnt_d = '0;
          if (phase_q == PHASE_LAST) begin
            state_d = ST_IDLE;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // LEDs are dark in blink phases 0 and 2, lit in phases 1 and 3.
  always_comb begin
    led_en = 1'b0;
    unique case (state_q)
      ST_SHOW:  led_en = 1'b1;
      ST_BLINK: led_en = phase_q[0];
      default:  led_en = 1'b0;
    endcase
  end

  onehot_dec3to8 u_led_dec (
    .en_i   (led_en),
    .code_i (code_q),
    .dec_o  (led_o)
  );

  always_comb begin
    seg_o = SEG_BLANK;
    if (state_q != ST_IDLE) begin
      seg_o = seg_digit(code_q);
    end
  end

  assign code_rdy_o = (state_q == ST_IDLE);
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dec38_led_drv.sv
// Drives two display drivers (HOLD=8/DIV=4 and HOLD=1/DIV=1) with shared stimulus
// and compares every cycle against a timeline model of the display behaviour.
module tb_dec38_led_drv;

  logic       clk;
  logic       rst_n;
  logic [2:0] code_i;
  logic       code_vld_i;

  logic       rdy_a, busy_a, rdy_b, busy_b;
  logic [7:0] led_a, seg_a, led_b, seg_b;

  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dec38_led_drv #(.HOLD_CYCLES(8), .BLINK_DIV(4), .CNT_W(16)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_i     (code_i),
    .code_vld_i (code_vld_i),
    .code_rdy_o (rdy_a),
    .led_o      (led_a),
    .seg_o      (seg_a),
    .busy_o     (busy_a)
  );

  dec38_led_drv #(.HOLD_CYCLES(1), .BLINK_DIV(1), .CNT_W(4)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_i     (code_i),
    .code_vld_i (code_vld_i),
    .code_rdy_o (rdy_b),
    .led_o      (led_b),
    .seg_o      (seg_b),
    .busy_o     (busy_b)
  );

  // Reference model: each instance is either idle or at some age (cycles since
  // acceptance); the display is a function of that age.
  int         hold_c  [2] = '{8, 1};
  int         blink_c [2] = '{4, 1};
  bit         m_busy  [2];
  int         m_age   [2];
  logic [2:0] m_code  [2];

  logic [7:0] digit_tab [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

  logic [7:0] exp_q[$];

  function automatic logic [7:0] exp_led(input int i);
    int ph;
    logic [7:0] one;
    one = 8'd1 << m_code[i];
    if (!m_busy[i]) return 8'h00;
    if (m_age[i] < hold_c[i]) return one;
    ph = (m_age[i] - hold_c[i]) / blink_c[i];
    return (ph % 2 == 1) ? one : 8'h00;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_age[i]  = 0;
        m_code[i] = 3'd0;
      end else if (!m_busy[i]) begin
        if (code_vld_i) begin
          m_busy[i] = 1'b1;
          m_age[i]  = 0;
          m_code[i] = code_i;
        end
      end else begin
        m_age[i]++;
        if (m_age[i] == hold_c[i] + 4 * blink_c[i]) m_busy[i] = 1'b0;
      end
      exp_q.push_back(exp_led(i));
      exp_q.push_back(m_busy[i] ? digit_tab[m_code[i]] : 8'hFF);
      exp_q.push_back({6'd0, !m_busy[i], m_busy[i]});
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Scoreboard: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() >= 6) begin
      check("led_a",  led_a,                    exp_q.pop_front());
      check("seg_a",  seg_a,                    exp_q.pop_front());
      check("hs_a",   {6'd0, rdy_a, busy_a},    exp_q.pop_front());
      check("led_b",  led_b,                    exp_q.pop_front());
      check("seg_b",  seg_b,                    exp_q.pop_front());
      check("hs_b",   {6'd0, rdy_b, busy_b},    exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic drive(input logic vld, input logic [2:0] code, input int n);
    for (int k = 0; k < n; k++) begin
      code_vld_i = vld;
      code_i     = code;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n      = 1'b0;
    code_vld_i = 1'b1;
    code_i     = 3'd3;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    code_vld_i = 1'b0;
    code_i     = 3'd0;
    #1;
    do_reset(2);
    drive(1'b0, 3'd0, 2);
    // single transfer of 5 and full blink sequence
    drive(1'b1, 3'd5, 1);
    drive(1'b0, 3'd0, 30);
    // input ignored while busy
    drive(1'b1, 3'd2, 1);
    drive(1'b0, 3'd0, 2);
    drive(1'b1, 3'd6, 3);
    drive(1'b0, 3'd0, 25);
    // held valid with code change while busy: back-to-back acceptance
    drive(1'b1, 3'd7, 11);
    drive(1'b1, 3'd0, 16);
    drive(1'b0, 3'd0, 30);
    // reset during blink phase 1, then a normal transfer
    drive(1'b1, 3'd4, 1);
    drive(1'b0, 3'd0, 13);
    do_reset(1);
    code_vld_i = 1'b0;
    drive(1'b1, 3'd1, 1);
    drive(1'b0, 3'd0, 30);
    // randomized traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        drive(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom_range(1, 4));
      end
    end
    drive(1'b0, 3'd0, 30);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
